// File: rtl/sqrt.sv
// Unsigned 8-bit integer square root, floor(sqrt(x)), restoring digit-by-digit
// method producing one result bit per clock behind a start/busy handshake.
module sqrt (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] x_bi,
    input  logic       start_i,
    output logic       busy_o,
    output logic [7:0] y_bo
);

    localparam int unsigned W = 8;
    localparam logic [W-1:0] M_INIT = W'(8'h40);

    typedef enum logic {
        IDLE = 1'b0,
        WORK = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   x_q, x_d;
    logic [W-1:0]   m_q, m_d;
    logic [W-1:0]   yacc_q, yacc_d;
    logic [W-1:0]   y_q, y_d;
    logic           busy_q, busy_d;

    logic [W-1:0]   b_c;
    logic [W-1:0]   ysh_c;
    logic [W-1:0]   ynext_c;
    logic           ge_c;
    logic           done_c;

    // One restoring iteration: trial bit b, conditional subtract.
    assign b_c     = yacc_q | m_q;
    assign ysh_c   = yacc_q >> 1;
    assign ge_c    = (x_q >= b_c);
    assign ynext_c = ge_c ? (ysh_c | m_q) : ysh_c;
    // Last iteration is the one whose mask shifts out to zero.
    assign done_c  = (state_q == WORK) && (m_q[W-1:2] == '0);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            m_q     <= '0;
            yacc_q  <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            m_q     <= m_d;
            yacc_q  <= yacc_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_i) state_d = WORK;
            WORK: if (done_c)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_d    = x_q;
        m_d    = m_q;
        yacc_d = yacc_q;
        y_d    = y_q;
        busy_d = busy_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d    = x_bi;
                    m_d    = M_INIT;
                    yacc_d = '0;
                    busy_d = 1'b1;
                end
            end
            WORK: begin
                m_d    = m_q >> 2;
                yacc_d = ynext_c;
                if (ge_c) begin
                    x_d = x_q - b_c;
                end
                if (done_c) begin
                    // Result fits in 4 bits; upper nibble stays zero.
                    y_d    = {4'b0000, ynext_c[3:0]};
                    busy_d = 1'b0;
                end
            end
            default: begin
                busy_d = 1'b0;
            end
        endcase
    end

    assign busy_o = busy_q;
    assign y_bo   = y_q;

endmodule

// File: tb/tb_sqrt.sv
// Directed self-checking bench for sqrt: reset, squares, non-squares, latency,
// mid-operation reset and held-start behaviour.
module tb_sqrt;

    logic       clk_i;
    logic       rst_i;
    logic [7:0] x_bi;
    logic       start_i;
    logic       busy_o;
    logic [7:0] y_bo;

    int passed = 0;
    int total  = 0;

    sqrt dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .x_bi    (x_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
        .y_bo    (y_bo)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy_o === 1'b1 && n < 15) begin
            step();
            n++;
        end
        check("busy_timeout", {7'b0, busy_o}, 8'd0);
    endtask

    task automatic run_sqrt(input string tag, input logic [7:0] xv, input logic [7:0] exp);
        x_bi    = xv;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        wait_idle();
        check(tag, y_bo, exp);
    endtask

    logic [7:0] ns_x [6];
    logic [7:0] ns_y [6];
    int         runs;
    logic       busy_prev;

    initial begin
        ns_x[0] = 8'd2;   ns_y[0] = 8'd1;
        ns_x[1] = 8'd8;   ns_y[1] = 8'd2;
        ns_x[2] = 8'd99;  ns_y[2] = 8'd9;
        ns_x[3] = 8'd255; ns_y[3] = 8'd15;
        ns_x[4] = 8'd15;  ns_y[4] = 8'd3;
        ns_x[5] = 8'd16;  ns_y[5] = 8'd4;

        // Reset held with start asserted: nothing may start.
        rst_i   = 1'b0;
        start_i = 1'b1;
        x_bi    = 8'd100;
        repeat (4) begin
            step();
            check("reset_busy", {7'b0, busy_o}, 8'd0);
            check("reset_y", y_bo, 8'd0);
        end

        // Release reset with start already high: first edge starts x=81.
        x_bi = 8'd81;
        #2 rst_i = 1'b1;
        step();
        start_i = 1'b0;
        check("release_start_busy", {7'b0, busy_o}, 8'd1);
        wait_idle();
        check("release_start_y", y_bo, 8'd9);

        for (int i = 0; i < 16; i++) begin
            run_sqrt("square", 8'(i * i), 8'(i));
        end

        for (int i = 0; i < 6; i++) begin
            run_sqrt("nonsquare", ns_x[i], ns_y[i]);
        end

        // Latency: busy for edges N..N+3, result after N+4; x changes ignored.
        x_bi    = 8'd200;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        check("lat_busy_n", {7'b0, busy_o}, 8'd1);
        x_bi = 8'd3;
        for (int k = 1; k < 4; k++) begin
            step();
            check("lat_busy_mid", {7'b0, busy_o}, 8'd1);
            check("lat_y_hold", y_bo, 8'd4);
            x_bi = 8'(k * 50);
        end
        step();
        check("lat_busy_fall", {7'b0, busy_o}, 8'd0);
        check("lat_y", y_bo, 8'd14);

        // Mid-operation reset aborts the run and clears the result.
        x_bi    = 8'd144;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        step();
        check("midrst_busy_pre", {7'b0, busy_o}, 8'd1);
        rst_i = 1'b0;
        #1;
        check("midrst_busy", {7'b0, busy_o}, 8'd0);
        check("midrst_y", y_bo, 8'd0);
        step();
        check("midrst_y_held", y_bo, 8'd0);
        rst_i = 1'b1;
        run_sqrt("midrst_restart", 8'd144, 8'd12);

        // Held start: repeated runs, result stays 7 after first completion.
        x_bi    = 8'd49;
        start_i = 1'b1;
        step();
        wait_idle();
        check("held_first", y_bo, 8'd7);
        runs      = 0;
        busy_prev = busy_o;
        for (int k = 0; k < 30; k++) begin
            step();
            if (busy_o && !busy_prev) runs++;
            busy_prev = busy_o;
            check("held_y", y_bo, 8'd7);
        end
        start_i = 1'b0;
        wait_idle();
        check("held_final", y_bo, 8'd7);
        check("held_runs", {7'b0, (runs >= 3)}, 8'd1);

        run_sqrt("zero_after", 8'd0, 8'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
